// File: rtl/micron_pkg.sv
// Shared constants and state encoding for the USB transmit scheduler.
package micron_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hAA;
   localparam logic [7:0] TYPE_IQ   = 8'h10;
   localparam logic [7:0] TYPE_BS   = 8'h80;
   localparam int         IQ_WORDS  = 128;
   localparam int         BS_CHUNKS = 64;

   typedef enum logic [2:0] {
      IDLE,
      HDR0,
      HDR1,
      FETCH,
      SEND,
      BS_END
   } tx_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level.
module sync2 (
   input  logic usb_clock,
   input  logic m_reset,
   input  logic d,
   output logic q
);

   logic meta;

   // Two back-to-back flops; the first may go metastable, the second settles it.
   always_ff @(posedge usb_clock or negedge m_reset) begin
      if (!m_reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/usb_tx_sched.sv
// USB byte-stream scheduler: interleaves IQ page bursts and bandscope chunks,
// each preceded by a two-byte header, reading words from external RAMs.
module usb_tx_sched
   import micron_pkg::*;
#(
   parameter int RD_LAT   = 2,
   parameter int BS_CHUNK = 256
) (
   input  logic        usb_clock,
   input  logic        m_reset,
   input  logic        rx_on,
   input  logic        bs_on,
   input  logic        adc_ram_block,
   input  logic        bs_ready,
   input  logic [47:0] adc_ram_rd_data,
   input  logic [15:0] bs_ram_rd_data,
   input  logic        tx_ready,
   output logic [7:0]  adc_ram_rd_addr,
   output logic [14:0] bs_ram_rd_addr,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   output logic        bs_done,
   output logic        iq_overrun,
   output logic        busy
);

   localparam int          LW    = $clog2(RD_LAT + 2);
   localparam logic [13:0] BSC14 = 14'(BS_CHUNK);

   tx_state_t   state, state_nx;
   logic        adc_s, adc_prev, bs_s, iq_edge;
   logic        iq_pend, iq_page, cur_page, is_iq;
   logic [5:0]  chunk;
   logic [13:0] word, addr_word;
   logic [2:0]  byte_cnt;
   logic [LW-1:0] lat_cnt;
   logic [47:0] shreg;
   logic        start_iq, start_bs, lat_done, last_byte, last_word;

   sync2 u_sync_adc (
      .usb_clock (usb_clock),
      .m_reset   (m_reset),
      .d         (adc_ram_block),
      .q         (adc_s)
   );

   sync2 u_sync_bs (
      .usb_clock (usb_clock),
      .m_reset   (m_reset),
      .d         (bs_ready),
      .q         (bs_s)
   );

   assign iq_edge   = adc_s ^ adc_prev;
   assign lat_done  = (lat_cnt == LW'(RD_LAT));
   assign last_byte = is_iq ? (byte_cnt == 3'd5) : (byte_cnt == 3'd1);
   assign last_word = is_iq ? (word == 14'(IQ_WORDS - 1)) : (word == 14'(BS_CHUNK - 1));
   // Word whose address is launched this cycle: word 0 from HDR1, next word from SEND.
   assign addr_word = (state == SEND) ? word + 14'd1 : word;

   // Page tracking: edge detect, pending flag with newest page, sticky overrun.
   always_ff @(posedge usb_clock or negedge m_reset) begin
      if (!m_reset) begin
         adc_prev   <= 1'b0;
         iq_pend    <= 1'b0;
         iq_page    <= 1'b0;
         iq_overrun <= 1'b0;
      end else begin
         adc_prev <= adc_s;
         if (!rx_on) begin
            iq_pend <= 1'b0;
         end else if (iq_edge) begin
            iq_pend <= 1'b1;
            iq_page <= adc_prev;
         end else if (start_iq) begin
            iq_pend <= 1'b0;
         end
         if (rx_on && iq_edge && (iq_pend || (state != IDLE && is_iq)))
            iq_overrun <= 1'b1;
      end
   end

   // State register.
   always_ff @(posedge usb_clock or negedge m_reset) begin
      if (!m_reset) state <= IDLE;
      else          state <= state_nx;
   end

   // Next state, arbitration strobes and the byte-stream outputs.
   always_comb begin
      state_nx = state;
      start_iq = 1'b0;
      start_bs = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      case (state)
         IDLE: begin
            if (iq_pend && rx_on) begin
               start_iq = 1'b1;
               state_nx = HDR0;
            end else if (bs_s && bs_on) begin
               start_bs = 1'b1;
               state_nx = HDR0;
            end
         end
         HDR0: begin
            tx_valid = 1'b1;
            tx_data  = SYNC_BYTE;
            if (tx_ready) state_nx = HDR1;
         end
         HDR1: begin
            tx_valid = 1'b1;
            tx_data  = is_iq ? (TYPE_IQ | {7'd0, cur_page}) : (TYPE_BS | {2'd0, chunk});
            if (tx_ready) state_nx = FETCH;
         end
         FETCH: begin
            if (lat_done) state_nx = SEND;
         end
         SEND: begin
            tx_valid = 1'b1;
            tx_data  = shreg[47:40];
            if (tx_ready && last_byte) begin
               if (!last_word)
                  state_nx = FETCH;
               else if (!is_iq && bs_on && chunk == 6'(BS_CHUNKS - 1))
                  state_nx = BS_END;
               else
                  state_nx = IDLE;
            end
         end
         BS_END: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign busy    = (state != IDLE);
   assign bs_done = (state == BS_END);

   // Burst datapath: address launch, read-latency count, word capture and byte shifting.
   always_ff @(posedge usb_clock or negedge m_reset) begin
      if (!m_reset) begin
         is_iq           <= 1'b0;
         cur_page        <= 1'b0;
         chunk           <= 6'd0;
         word            <= 14'd0;
         byte_cnt        <= 3'd0;
         lat_cnt         <= '0;
         shreg           <= 48'd0;
         adc_ram_rd_addr <= 8'd0;
         bs_ram_rd_addr  <= 15'd0;
      end else begin
         case (state)
            IDLE: begin
               word <= 14'd0;
               if (start_iq) begin
                  is_iq    <= 1'b1;
                  cur_page <= iq_page;
               end else if (start_bs) begin
                  is_iq <= 1'b0;
               end
            end
            HDR1: begin
               if (tx_ready) begin
                  lat_cnt <= '0;
                  if (is_iq) adc_ram_rd_addr <= {cur_page, addr_word[6:0]};
                  else       bs_ram_rd_addr  <= {1'b0, 14'(chunk) * BSC14 + addr_word};
               end
            end
            FETCH: begin
               lat_cnt <= lat_cnt + 1'b1;
               if (lat_done) begin
                  shreg    <= is_iq ? adc_ram_rd_data : {bs_ram_rd_data, 32'd0};
                  byte_cnt <= 3'd0;
               end
            end
            SEND: begin
               if (tx_ready) begin
                  shreg    <= {shreg[39:0], 8'h00};
                  byte_cnt <= byte_cnt + 3'd1;
                  if (last_byte) begin
                     if (!last_word) begin
                        word    <= addr_word;
                        lat_cnt <= '0;
                        if (is_iq) adc_ram_rd_addr <= {cur_page, addr_word[6:0]};
                        else       bs_ram_rd_addr  <= {1'b0, 14'(chunk) * BSC14 + addr_word};
                     end else if (!is_iq) begin
                        // Frame wraps after the last chunk, or restarts if bandscope was switched off.
                        chunk <= (!bs_on || chunk == 6'(BS_CHUNKS - 1)) ? 6'd0 : chunk + 6'd1;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_usb_tx_sched.sv
// Randomized scoreboard bench for usb_tx_sched: RAM contents are random, the
// expected byte stream is built from page/chunk arithmetic and checked by a monitor.
module tb_usb_tx_sched;

   localparam int RD_LAT = 2;
   localparam int BSC    = 32;
   localparam int CHUNK_BYTES = 2 + 2 * BSC;

   logic        usb_clock = 1'b0;
   logic        m_reset = 1'b0;
   logic        rx_on = 1'b0;
   logic        bs_on = 1'b0;
   logic        adc_ram_block = 1'b0;
   logic        bs_ready = 1'b0;
   logic        tx_ready = 1'b0;
   logic [47:0] adc_ram_rd_data;
   logic [15:0] bs_ram_rd_data;
   logic [7:0]  adc_ram_rd_addr;
   logic [14:0] bs_ram_rd_addr;
   logic [7:0]  tx_data;
   logic        tx_valid, bs_done, iq_overrun, busy;

   usb_tx_sched #(.RD_LAT(RD_LAT), .BS_CHUNK(BSC)) dut (
      .usb_clock       (usb_clock),
      .m_reset         (m_reset),
      .rx_on           (rx_on),
      .bs_on           (bs_on),
      .adc_ram_block   (adc_ram_block),
      .bs_ready        (bs_ready),
      .adc_ram_rd_data (adc_ram_rd_data),
      .bs_ram_rd_data  (bs_ram_rd_data),
      .tx_ready        (tx_ready),
      .adc_ram_rd_addr (adc_ram_rd_addr),
      .bs_ram_rd_addr  (bs_ram_rd_addr),
      .tx_data         (tx_data),
      .tx_valid        (tx_valid),
      .bs_done         (bs_done),
      .iq_overrun      (iq_overrun),
      .busy            (busy)
   );

   always #5 usb_clock = ~usb_clock;

   // RAM models: q appears RD_LAT clocks after the address.
   logic [47:0] iq_mem [256];
   logic [15:0] bs_mem [16384];
   logic [47:0] iq_pipe [RD_LAT];
   logic [15:0] bs_pipe [RD_LAT];

   always @(posedge usb_clock) begin
      iq_pipe[0] <= iq_mem[adc_ram_rd_addr];
      bs_pipe[0] <= bs_mem[bs_ram_rd_addr[13:0]];
      for (int i = 1; i < RD_LAT; i++) begin
         iq_pipe[i] <= iq_pipe[i-1];
         bs_pipe[i] <= bs_pipe[i-1];
      end
   end

   assign adc_ram_rd_data = iq_pipe[RD_LAT-1];
   assign bs_ram_rd_data  = bs_pipe[RD_LAT-1];

   logic [7:0] exp_q[$];
   int checks = 0;
   int failures = 0;
   int nbytes = 0;
   int bs_done_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (byte %0d, t=%0t)", name, act, exp, nbytes, $time);
      end
   endtask

   // Reference stream for one IQ page: header then 128 words, 6 bytes MSB first.
   task automatic push_iq(input int page);
      logic [47:0] d;
      exp_q.push_back(8'hAA);
      exp_q.push_back(8'h10 | 8'(page));
      for (int w = 0; w < 128; w++) begin
         d = iq_mem[page * 128 + w];
         for (int b = 5; b >= 0; b--) exp_q.push_back(d[b*8 +: 8]);
      end
   endtask

   // Reference stream for one bandscope chunk: header then BSC words, 2 bytes MSB first.
   task automatic push_bs(input int chunk);
      logic [15:0] d;
      exp_q.push_back(8'hAA);
      exp_q.push_back(8'h80 | 8'(chunk));
      for (int i = 0; i < BSC; i++) begin
         d = bs_mem[chunk * BSC + i];
         exp_q.push_back(d[15:8]);
         exp_q.push_back(d[7:0]);
      end
   endtask

   // Monitor: compares every accepted byte and checks stall stability.
   initial begin
      logic       stall_prev;
      logic [7:0] prev_data;
      logic [7:0] e;
      stall_prev = 1'b0;
      prev_data  = 8'h00;
      forever begin
         @(negedge usb_clock);
         if (!m_reset) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               chk("stall_valid_held", 64'(tx_valid), 64'd1);
               chk("stall_data_held", 64'(tx_data), 64'(prev_data));
            end
            if (tx_valid && tx_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_byte: got %0h expected no byte (t=%0t)", tx_data, $time);
               end else begin
                  e = exp_q.pop_front();
                  chk("tx_byte", 64'(tx_data), 64'(e));
               end
               nbytes++;
            end
            if (bs_done) bs_done_cnt++;
            stall_prev = tx_valid && !tx_ready;
            prev_data  = tx_data;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge usb_clock);
         #1;
      end
   endtask

   task automatic wait_idle(input int maxc, input bit toggle, input string name);
      int c = 0;
      while ((exp_q.size() != 0 || busy) && c < maxc) begin
         if (toggle) tx_ready = ~tx_ready;
         tick(1);
         c++;
      end
      if (c >= maxc) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: %0d bytes still expected, busy=%0b", name, exp_q.size(), busy);
         exp_q.delete();
      end
   endtask

   task automatic wait_q_le(input int n, input int maxc, input string name);
      int c = 0;
      while (exp_q.size() > n && c < maxc) begin
         tick(1);
         c++;
      end
      if (c >= maxc) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: queue %0d required <= %0d", name, exp_q.size(), n);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_tx_valid"}, 64'(tx_valid), 64'd0);
      chk({tag, "_tx_data"}, 64'(tx_data), 64'd0);
      chk({tag, "_bs_done"}, 64'(bs_done), 64'd0);
      chk({tag, "_iq_overrun"}, 64'(iq_overrun), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_adc_addr"}, 64'(adc_ram_rd_addr), 64'd0);
      chk({tag, "_bs_addr"}, 64'(bs_ram_rd_addr), 64'd0);
   endtask

   initial begin
      int lat, total, n0, n1, c;
      for (int i = 0; i < 256; i++)   iq_mem[i] = 48'({$urandom, $urandom});
      for (int i = 0; i < 16384; i++) bs_mem[i] = 16'($urandom);

      // Reset state.
      tick(3);
      check_all_zero("reset");
      m_reset = 1'b1;
      rx_on = 1'b1;
      bs_on = 1'b1;
      tx_ready = 1'b1;
      tick(5);
      chk("idle_after_release_busy", 64'(busy), 64'd0);

      // IQ page 0 at full rate, with header latency from the pin edge.
      push_iq(0);
      adc_ram_block = 1'b1;
      lat = 0;
      while (!tx_valid && lat < 12) begin
         tick(1);
         lat++;
      end
      checks++;
      if (lat > 4) begin
         failures++;
         $display("FAIL iq_hdr_latency: got %0d cycles required <= 4", lat);
      end
      wait_idle(3000, 1'b0, "iq_page0");
      chk("iq0_busy_done", 64'(busy), 64'd0);
      chk("iq0_no_overrun", 64'(iq_overrun), 64'd0);

      // IQ page 1 with tx_ready toggling every cycle.
      push_iq(1);
      adc_ram_block = 1'b0;
      wait_idle(6000, 1'b1, "iq_toggle");
      tx_ready = 1'b1;
      chk("iq1_no_overrun", 64'(iq_overrun), 64'd0);

      // Full bandscope frame with an IQ page inserted after chunk 5.
      for (int k = 0; k <= 5; k++) push_bs(k);
      push_iq(0);
      for (int k = 6; k < 64; k++) push_bs(k);
      total = exp_q.size();
      bs_ready = 1'b1;
      wait_q_le(total - (5 * CHUNK_BYTES + 4), 20000, "reach_chunk5");
      adc_ram_block = 1'b1;
      wait_q_le(2 * BSC, 20000, "reach_chunk63");
      bs_ready = 1'b0;
      wait_idle(20000, 1'b0, "bs_frame");
      tick(5);
      chk("bs_done_pulses", 64'(bs_done_cnt), 64'd1);
      chk("bs_no_overrun", 64'(iq_overrun), 64'd0);

      // Two IQ edges while stalled behind a bandscope chunk: overrun, newest page wins.
      tx_ready = 1'b0;
      bs_ready = 1'b1;
      c = 0;
      while (!busy && c < 20) begin
         tick(1);
         c++;
      end
      chk("bs_stall_started", 64'(busy), 64'd1);
      bs_ready = 1'b0;
      push_bs(0);
      tick(2);
      adc_ram_block = 1'b0;
      tick(8);
      chk("first_edge_no_overrun", 64'(iq_overrun), 64'd0);
      adc_ram_block = 1'b1;
      tick(8);
      chk("second_edge_overrun", 64'(iq_overrun), 64'd1);
      push_iq(0);
      tx_ready = 1'b1;
      wait_idle(5000, 1'b0, "overrun");
      tick(5);
      chk("overrun_sticky", 64'(iq_overrun), 64'd1);
      chk("no_extra_bs_done", 64'(bs_done_cnt), 64'd1);

      // Reset in the middle of an IQ burst.
      push_iq(1);
      adc_ram_block = 1'b0;
      n0 = nbytes;
      c = 0;
      while (nbytes - n0 < 300 && c < 5000) begin
         tick(1);
         c++;
      end
      chk("reached_byte300", 64'(nbytes - n0 >= 300), 64'd1);
      m_reset = 1'b0;
      #1;
      check_all_zero("midreset");
      exp_q.delete();
      tick(3);
      m_reset = 1'b1;
      n1 = nbytes;
      tick(40);
      chk("silent_after_release", 64'(nbytes), 64'(n1));
      chk("idle_after_midreset", 64'(busy), 64'd0);

      // A fresh edge after reset is served normally.
      push_iq(0);
      adc_ram_block = 1'b1;
      wait_idle(3000, 1'b0, "post_reset_iq");
      chk("post_reset_no_overrun", 64'(iq_overrun), 64'd0);
      chk("bs_addr_bit14", 64'(bs_ram_rd_addr[14]), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/usb_tx_sched.md
USB_TX_SCHED -- requirements
Module: usb_tx_sched

Interface
REQ-001 SHALL have parameter RD_LAT, default 2, meaning RAM read latency in usb_clock cycles from address to valid q.
REQ-002 SHALL have parameter BS_CHUNK, default 256, meaning bandscope words per burst.
REQ-003 SHALL have port usb_clock, input, 1, meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port m_reset, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port rx_on, input, 1, meaning IQ streaming enabled.
REQ-006 SHALL have port bs_on, input, 1, meaning bandscope streaming enabled.
REQ-007 SHALL have port adc_ram_block, input, 1, meaning IQ page under write; async from the 76.8 MHz domain; each toggle completes one page.
REQ-008 SHALL have port bs_ready, input, 1, meaning bandscope RAM full; async level.
REQ-009 SHALL have port adc_ram_rd_data, input, 48, meaning IQ RAM q.
REQ-010 SHALL have port bs_ram_rd_data, input, 16, meaning bandscope RAM q.
REQ-011 SHALL have port tx_ready, input, 1, meaning the byte sink accepts.
REQ-012 SHALL have port adc_ram_rd_addr, output, 8, meaning IQ RAM address; bit 7 is the page.
REQ-013 SHALL have port bs_ram_rd_addr, output, 15, meaning bandscope RAM address; bit 14 is always 0.
REQ-014 SHALL have port tx_data, output, 8, meaning stream byte.
REQ-015 SHALL have port tx_valid, output, 1, meaning tx_data valid.
REQ-016 SHALL have port bs_done, output, 1, meaning one-cycle pulse when a full bandscope frame has been sent.
REQ-017 SHALL have port iq_overrun, output, 1, meaning sticky IQ page-loss flag.
REQ-018 SHALL have port busy, output, 1, meaning high in any state other than IDLE.

Function
REQ-019 SHALL synchronize adc_ram_block and bs_ready with 2 flops each; an IQ edge is any change of the synchronized adc_ram_block.
REQ-020 SHALL, on an IQ edge while rx_on=1, set iq_pend and latch iq_page = the pre-edge synchronized value.
REQ-021 SHALL set iq_overrun if an IQ edge occurs while iq_pend=1 or while in IQ_DATA; the current burst completes, and iq_pend/iq_page take the newest page.
REQ-022 SHALL clear iq_pend whenever rx_on=0.
REQ-023 SHALL use states IDLE, HDR0, HDR1, FETCH, SEND, BS_END.
REQ-024 SHALL arbitrate only in IDLE: iq_pend wins; otherwise start a BS chunk if synchronized bs_ready=1 and bs_on=1; otherwise stay in IDLE.
REQ-025 SHALL never preempt a burst once HDR0 is entered.
REQ-026 SHALL emit the header as HDR0 = 8'hAA, then HDR1 = 8'h10|iq_page for IQ or 8'h80|chunk[5:0] for BS.
REQ-027 SHALL form an IQ burst from 128 words at addresses {iq_page, 7'd0..127}, 6 bytes each, [47:40] first.
REQ-028 SHALL form a BS chunk from BS_CHUNK words at chunk*BS_CHUNK+i, 2 bytes each, [15:8] first; a frame is 64 chunks.
REQ-029 SHALL handle each word in FETCH by driving the address, then capturing q exactly RD_LAT cycles later into a shift register, then moving to SEND.
REQ-030 SHALL transfer a byte only when tx_valid & tx_ready; tx_data SHALL be held stable while tx_valid=1 and tx_ready=0.
REQ-031 SHALL, after the last byte of a word, go to FETCH for the next word, or to IDLE at end of burst.
REQ-032 SHALL, after BS chunk 63, go to BS_END, pulse bs_done for 1 cycle, reset chunk to 0, then go to IDLE.
REQ-033 SHALL, if bs_on=0 at a chunk boundary, reset chunk to 0 without asserting bs_done.
REQ-034 SHALL ignore a bs_ready fall mid-chunk.
REQ-035 SHALL drive HDR0 with tx_valid no later than 4 cycles after an IQ edge arrives at the input pins while in IDLE.

Reset
REQ-036 SHALL, while m_reset=0, hold state=IDLE; tx_valid, tx_data, bs_done, iq_overrun, busy, iq_pend, chunk and both addresses = 0; synchronizers = 0.
REQ-037 SHALL, on reset assertion mid-burst, abort immediately and emit no partial bytes after release.
REQ-038 SHALL clear iq_overrun only by reset.

Structure
REQ-039 SHALL place SYNC_BYTE=8'hAA, TYPE_IQ=8'h10, TYPE_BS=8'h80, IQ_WORDS=128, BS_CHUNKS=64 and the state enum in shared package micron_pkg.
REQ-040 SHALL implement the two-flop synchronizer as sub-module sync2, instantiated twice.

Verification
REQ-041 SHALL cover: adc_ram_block 0->1 with rx_on=1 and tx_ready=1 -> AA,10, then 768 bytes from addresses 0..127 MSB-first; busy returns to 0.
REQ-042 SHALL cover: bs_ready=1 with bs_on=1 -> 64 bursts AA,80..AA,BF of 512 bytes each; one bs_done pulse; addresses 0..16383.
REQ-043 SHALL cover: an IQ edge during BS chunk 5 -> chunk 5 completes, the IQ burst follows, then chunk 6.
REQ-044 SHALL cover: two IQ edges with no service between them (tx_ready=0) -> iq_overrun=1 and only the newest page is sent.
REQ-045 SHALL cover: tx_ready toggling 1010... -> tx_data stable while stalled; byte sequence identical to the REQ-041 scenario.
REQ-046 SHALL cover: m_reset low at byte 300 of an IQ burst -> all outputs 0 within 1 cycle; after release, IDLE with no output until a new edge.
